// File: rtl/m7232_useq.sv
// KD11 microprogram sequencer: holds uword/upc, next address = upf | bubc (or TRAP_UPC).
// A step shows rom_addr and clk_ir one cycle later and the new uword the cycle after; PAUSE waits for bus_done, STOP waits for ucont.
module m7232_useq #(
   parameter int              UA_W      = 8,
   parameter int              UW_W      = 48,
   parameter logic [UA_W-1:0] PWRUP_UPC = 8'o000,
   parameter logic [UA_W-1:0] TRAP_UPC  = 8'o376
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            ustep,
   input  logic [5:0]      bubc,
   input  logic            bus_done,
   input  logic            force_trap,
   input  logic [UW_W-1:0] rom_data,
   input  logic            ubreak_en,
   input  logic [UA_W-1:0] ubreak_addr,
   input  logic            ucont,
   output logic [UA_W-1:0] rom_addr,
   output logic [UA_W-1:0] upc,
   output logic [UW_W-1:0] uword,
   output logic [4:0]      ubf,
   output logic            uword_valid,
   output logic            clk_ir,
   output logic            ustop
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_VALID = 2'd1,
      S_PAUSE = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [UA_W-1:0] r_rom_addr;
   logic [UA_W-1:0] w_rom_addr_nxt;
   logic [UA_W-1:0] r_upc;
   logic [UA_W-1:0] w_upc_nxt;
   logic [UW_W-1:0] r_uword;
   logic [UW_W-1:0] w_uword_nxt;
   logic            r_valid;
   logic            w_valid_nxt;
   logic            r_clk_ir;
   logic            w_clk_ir_nxt;
   logic            r_ustop;
   logic            w_ustop_nxt;

   logic            w_step;
   logic            w_load_ir;
   logic            w_pause;
   logic            w_bp_hit;
   logic [7:0]      w_or_addr;
   logic [UA_W-1:0] w_next_addr;

   assign w_load_ir = r_uword[13];
   assign w_pause   = r_uword[14];

   // Plain bitwise OR: the branch bits select within an aligned dispatch block, never carry.
   assign w_or_addr   = r_uword[7:0] | {2'b00, bubc};
   assign w_next_addr = force_trap ? TRAP_UPC : UA_W'(w_or_addr);
   assign w_bp_hit    = ubreak_en && (r_rom_addr == ubreak_addr);

   always_comb begin
      w_state_nxt    = r_state;
      w_rom_addr_nxt = r_rom_addr;
      w_upc_nxt      = r_upc;
      w_uword_nxt    = r_uword;
      w_valid_nxt    = r_valid;
      w_clk_ir_nxt   = 1'b0;
      w_ustop_nxt    = r_ustop;
      w_step         = 1'b0;

      case (r_state)
         S_FETCH: begin
            w_uword_nxt = rom_data;
            w_upc_nxt   = r_rom_addr;
            w_valid_nxt = 1'b1;
            if (w_bp_hit) begin
               w_state_nxt = S_STOP;
               w_ustop_nxt = 1'b1;
            end else begin
               w_state_nxt = S_VALID;
            end
         end
         S_VALID: begin
            if (ustep) begin
               if (w_pause && !bus_done) begin
                  w_state_nxt = S_PAUSE;
               end else begin
                  w_step = 1'b1;
               end
            end
         end
         S_PAUSE: begin
            if (bus_done) begin
               w_step = 1'b1;
            end
         end
         S_STOP: begin
            if (ucont) begin
               w_ustop_nxt = 1'b0;
               w_state_nxt = S_VALID;
            end
         end
         default: begin
            w_state_nxt = S_FETCH;
         end
      endcase

      // clk_ir reflects the uword being left, not the one being fetched.
      if (w_step) begin
         w_rom_addr_nxt = w_next_addr;
         w_valid_nxt    = 1'b0;
         w_state_nxt    = S_FETCH;
         w_clk_ir_nxt   = w_load_ir;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_FETCH;
         r_rom_addr <= PWRUP_UPC;
         r_upc      <= '0;
         r_uword    <= '0;
         r_valid    <= 1'b0;
         r_clk_ir   <= 1'b0;
         r_ustop    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_rom_addr <= w_rom_addr_nxt;
         r_upc      <= w_upc_nxt;
         r_uword    <= w_uword_nxt;
         r_valid    <= w_valid_nxt;
         r_clk_ir   <= w_clk_ir_nxt;
         r_ustop    <= w_ustop_nxt;
      end
   end

   assign rom_addr    = r_rom_addr;
   assign upc         = r_upc;
   assign uword       = r_uword;
   assign ubf         = r_uword[12:8];
   assign uword_valid = r_valid;
   assign clk_ir      = r_clk_ir;
   assign ustop       = r_ustop;

endmodule

// File: tb/tb_m7232_useq.sv
// Bench for m7232_useq: a small microprogram in a bench ROM, walked step by step with a queue of expected microaddresses.
module tb_m7232_useq;
   localparam int UA_W = 8;
   localparam int UW_W = 48;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            ustep = 1'b0;
   logic [5:0]      bubc = 6'd0;
   logic            bus_done = 1'b0;
   logic            force_trap = 1'b0;
   logic [UW_W-1:0] rom_data;
   logic            ubreak_en = 1'b0;
   logic [UA_W-1:0] ubreak_addr = 8'd0;
   logic            ucont = 1'b0;
   logic [UA_W-1:0] rom_addr;
   logic [UA_W-1:0] upc;
   logic [UW_W-1:0] uword;
   logic [4:0]      ubf;
   logic            uword_valid;
   logic            clk_ir;
   logic            ustop;

   logic [UW_W-1:0] rom [0:255];
   logic [7:0]      exp_q [$];
   int              n_vec = 0;
   int              n_err = 0;

   m7232_useq #(.UA_W(UA_W), .UW_W(UW_W), .PWRUP_UPC(8'o000), .TRAP_UPC(8'o376)) dut (
      .clk(clk), .reset(reset), .ustep(ustep), .bubc(bubc), .bus_done(bus_done),
      .force_trap(force_trap), .rom_data(rom_data), .ubreak_en(ubreak_en),
      .ubreak_addr(ubreak_addr), .ucont(ucont), .rom_addr(rom_addr), .upc(upc),
      .uword(uword), .ubf(ubf), .uword_valid(uword_valid), .clk_ir(clk_ir), .ustop(ustop)
   );

   always #5 clk = ~clk;
   assign rom_data = rom[rom_addr];

   function automatic logic [47:0] mk(input logic [7:0] upf, input logic [4:0] ubf_f,
                                      input logic ir, input logic pz);
      return {33'h05A5A5A5A ^ {25'h0, upf}, pz, ir, ubf_f, upf};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_ustep();
      ustep = 1'b1;
      tick();
      ustep = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] e;
      int k;
      reset = 1'b1;
      #1;
      n_vec++;
      if ({rom_addr, upc, uword, uword_valid, clk_ir, ustop} !== {8'o000, 8'h00, 48'h0, 3'b000}) begin
         n_err++;
         $display("FAIL reset_values: addr=%o upc=%o uword=%h v=%b ir=%b stop=%b, need 000/0/0/0/0/0",
                  rom_addr, upc, uword, uword_valid, clk_ir, ustop);
      end
      tick();
      tick();
      reset = 1'b0;
      exp_q.push_back(8'o000);
      k = 0;
      do begin
         tick();
         k++;
      end while (!uword_valid && k < 8);
      n_vec++;
      if (!uword_valid || k > 2) begin
         n_err++;
         $display("FAIL reset_first_valid: valid=%b after %0d edges, need 1 within 2", uword_valid, k);
      end
      e = exp_q.pop_front();
      n_vec++;
      if (upc !== e || uword !== 48'h0000_0000_0105 || ubf !== 5'h01) begin
         n_err++;
         $display("FAIL reset_first_uword: upc=%o uword=%h ubf=%h, need %o 000000000105 01", upc, uword, ubf, e);
      end
   endtask

   task automatic test_or_step();
      logic [5:0] bc [3];
      logic [7:0] ea [3];
      logic [7:0] e;
      bc = '{6'o00, 6'o05, 6'o77};
      ea = '{8'o005, 8'o045, 8'o377};
      for (int i = 0; i < 3; i++) begin
         bubc = bc[i];
         exp_q.push_back(ea[i]);
         pulse_ustep();
         n_vec++;
         if (rom_addr !== ea[i]) begin
            n_err++;
            $display("FAIL or_rom_addr[%0d]: got %o need %o", i, rom_addr, ea[i]);
         end
         tick();
         e = exp_q.pop_front();
         n_vec++;
         if (upc !== e || uword !== rom[e] || !uword_valid) begin
            n_err++;
            $display("FAIL or_upc[%0d]: upc=%o uword=%h v=%b need %o %h 1", i, upc, uword, uword_valid, e, rom[e]);
         end
      end
      bubc = 6'o00;
   endtask

   task automatic test_clk_ir();
      logic [7:0] e;
      logic seen;
      exp_q.push_back(8'o040);
      pulse_ustep();
      n_vec++;
      if (clk_ir !== 1'b1 || rom_addr !== 8'o040) begin
         n_err++;
         $display("FAIL clk_ir_pulse: clk_ir=%b addr=%o need 1 040", clk_ir, rom_addr);
      end
      tick();
      e = exp_q.pop_front();
      n_vec++;
      if (clk_ir !== 1'b0 || upc !== e) begin
         n_err++;
         $display("FAIL clk_ir_width: clk_ir=%b upc=%o need 0 %o", clk_ir, upc, e);
      end
      exp_q.push_back(8'o100);
      pulse_ustep();
      seen = clk_ir;
      tick();
      seen |= clk_ir;
      e = exp_q.pop_front();
      n_vec++;
      if (upc !== e) begin
         n_err++;
         $display("FAIL clk_ir_step2_upc: got %o need %o", upc, e);
      end
      tick();
      seen |= clk_ir;
      n_vec++;
      if (seen !== 1'b0) begin
         n_err++;
         $display("FAIL clk_ir_quiet: clk_ir seen=%b need 0", seen);
      end
   endtask

   task automatic test_pause();
      logic [7:0] e;
      logic held;
      bus_done = 1'b0;
      pulse_ustep();
      held = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i % 3 == 1) ustep = 1'b1;
         tick();
         ustep = 1'b0;
         if (rom_addr !== 8'o100 || clk_ir !== 1'b0 || uword_valid !== 1'b1) held = 1'b0;
      end
      n_vec++;
      if (!held) begin
         n_err++;
         $display("FAIL pause_hold: addr=%o clk_ir=%b need 100 held 10 cycles", rom_addr, clk_ir);
      end
      exp_q.push_back(8'o120);
      bus_done = 1'b1;
      tick();
      bus_done = 1'b0;
      n_vec++;
      if (rom_addr !== 8'o120 || clk_ir !== 1'b1) begin
         n_err++;
         $display("FAIL pause_release: addr=%o clk_ir=%b need 120 1", rom_addr, clk_ir);
      end
      tick();
      e = exp_q.pop_front();
      n_vec++;
      if (upc !== e || clk_ir !== 1'b0) begin
         n_err++;
         $display("FAIL pause_upc: upc=%o clk_ir=%b need %o 0", upc, clk_ir, e);
      end
      exp_q.push_back(8'o010);
      bus_done = 1'b1;
      pulse_ustep();
      bus_done = 1'b0;
      n_vec++;
      if (rom_addr !== 8'o010) begin
         n_err++;
         $display("FAIL pause_bus_done_early: addr=%o need 010", rom_addr);
      end
      tick();
      e = exp_q.pop_front();
      n_vec++;
      if (upc !== e) begin
         n_err++;
         $display("FAIL pause_early_upc: got %o need %o", upc, e);
      end
   endtask

   task automatic test_force_trap();
      logic [7:0] e;
      bubc = 6'o03;
      force_trap = 1'b1;
      exp_q.push_back(8'o376);
      pulse_ustep();
      force_trap = 1'b0;
      bubc = 6'o00;
      n_vec++;
      if (rom_addr !== 8'o376) begin
         n_err++;
         $display("FAIL trap_addr: got %o need 376 (not 013)", rom_addr);
      end
      tick();
      e = exp_q.pop_front();
      n_vec++;
      if (upc !== e) begin
         n_err++;
         $display("FAIL trap_upc: got %o need %o", upc, e);
      end
   endtask

   task automatic test_breakpoint();
      logic [7:0] e;
      logic held;
      ucont = 1'b1;
      tick();
      ucont = 1'b0;
      n_vec++;
      if (ustop !== 1'b0 || uword_valid !== 1'b1 || upc !== 8'o376) begin
         n_err++;
         $display("FAIL stray_ucont: stop=%b v=%b upc=%o need 0 1 376", ustop, uword_valid, upc);
      end
      ubreak_en = 1'b1;
      ubreak_addr = 8'o045;
      bubc = 6'o05;
      exp_q.push_back(8'o045);
      pulse_ustep();
      bubc = 6'o00;
      tick();
      e = exp_q.pop_front();
      n_vec++;
      if (ustop !== 1'b1 || uword_valid !== 1'b1 || upc !== e) begin
         n_err++;
         $display("FAIL bp_stop: stop=%b v=%b upc=%o need 1 1 %o", ustop, uword_valid, upc, e);
      end
      held = 1'b1;
      repeat (5) begin
         ustep = 1'b1;
         tick();
         ustep = 1'b0;
         tick();
         if (rom_addr !== 8'o045 || ustop !== 1'b1) held = 1'b0;
      end
      n_vec++;
      if (!held) begin
         n_err++;
         $display("FAIL bp_hold: addr=%o stop=%b need 045 1", rom_addr, ustop);
      end
      ucont = 1'b1;
      tick();
      ucont = 1'b0;
      n_vec++;
      if (ustop !== 1'b0) begin
         n_err++;
         $display("FAIL bp_ucont: stop=%b need 0", ustop);
      end
      exp_q.push_back(8'o377);
      pulse_ustep();
      n_vec++;
      if (rom_addr !== 8'o377) begin
         n_err++;
         $display("FAIL bp_resume_addr: got %o need 377", rom_addr);
      end
      tick();
      e = exp_q.pop_front();
      n_vec++;
      if (upc !== e || ustop !== 1'b0) begin
         n_err++;
         $display("FAIL bp_resume_upc: upc=%o stop=%b need %o 0", upc, ustop, e);
      end
      ubreak_addr = 8'o376;
      force_trap = 1'b1;
      exp_q.push_back(8'o376);
      pulse_ustep();
      force_trap = 1'b0;
      tick();
      e = exp_q.pop_front();
      n_vec++;
      if (ustop !== 1'b1 || upc !== e) begin
         n_err++;
         $display("FAIL bp_on_trap: stop=%b upc=%o need 1 %o", ustop, upc, e);
      end
      ucont = 1'b1;
      tick();
      ucont = 1'b0;
      ubreak_en = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [7:0] e;
      bus_done = 1'b1;
      bubc = 6'o00;
      foreach (exp_q[i]) exp_q.delete(i);
      exp_q.push_back(8'o040); exp_q.push_back(8'o040);
      exp_q.push_back(8'o100); exp_q.push_back(8'o100);
      exp_q.push_back(8'o120); exp_q.push_back(8'o120);
      exp_q.push_back(8'o010); exp_q.push_back(8'o010);
      ustep = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         e = exp_q.pop_front();
         n_vec++;
         if (rom_addr !== e) begin
            n_err++;
            $display("FAIL b2b_addr[%0d]: got %o need %o", i, rom_addr, e);
         end
      end
      ustep = 1'b0;
      bus_done = 1'b0;
      n_vec++;
      if (upc !== 8'o010 || uword_valid !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_final: upc=%o v=%b need 010 1", upc, uword_valid);
      end
   endtask

   task automatic test_reset_mid();
      int k;
      bubc = 6'o02;
      pulse_ustep();
      bubc = 6'o00;
      tick();
      n_vec++;
      if (upc !== 8'o012) begin
         n_err++;
         $display("FAIL rmid_upc: got %o need 012", upc);
      end
      pulse_ustep();
      tick();
      reset = 1'b1;
      #1;
      n_vec++;
      if ({rom_addr, upc, uword, uword_valid, clk_ir, ustop} !== {8'o000, 8'h00, 48'h0, 3'b000}) begin
         n_err++;
         $display("FAIL rmid_pause_reset: addr=%o upc=%o v=%b ir=%b need 000 0 0 0", rom_addr, upc, uword_valid, clk_ir);
      end
      tick();
      reset = 1'b0;
      k = 0;
      do begin
         tick();
         k++;
      end while (!uword_valid && k < 8);
      pulse_ustep();
      tick();
      pulse_ustep();
      n_vec++;
      if (clk_ir !== 1'b1 || rom_addr !== 8'o040) begin
         n_err++;
         $display("FAIL rmid_fetch_setup: clk_ir=%b addr=%o need 1 040", clk_ir, rom_addr);
      end
      reset = 1'b1;
      #1;
      n_vec++;
      if (clk_ir !== 1'b0 || rom_addr !== 8'o000 || uword_valid !== 1'b0) begin
         n_err++;
         $display("FAIL rmid_fetch_reset: clk_ir=%b addr=%o v=%b need 0 000 0", clk_ir, rom_addr, uword_valid);
      end
      tick();
      reset = 1'b0;
      k = 0;
      do begin
         tick();
         k++;
      end while (!uword_valid && k < 8);
      n_vec++;
      if (!uword_valid || upc !== 8'o000 || uword !== rom[0]) begin
         n_err++;
         $display("FAIL rmid_recover: v=%b upc=%o uword=%h need 1 000 %h", uword_valid, upc, uword, rom[0]);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = mk(8'hFF, 5'h1F, 1'b0, 1'b0);
      rom[8'o000] = 48'h0000_0000_0105;
      rom[8'o005] = mk(8'o040, 5'd3, 1'b1, 1'b0);
      rom[8'o045] = mk(8'o377, 5'd7, 1'b0, 1'b0);
      rom[8'o377] = mk(8'o040, 5'd9, 1'b1, 1'b0);
      rom[8'o040] = mk(8'o100, 5'd2, 1'b0, 1'b0);
      rom[8'o100] = mk(8'o120, 5'd4, 1'b1, 1'b1);
      rom[8'o120] = mk(8'o010, 5'd6, 1'b0, 1'b1);
      rom[8'o010] = mk(8'o010, 5'd1, 1'b0, 1'b0);
      rom[8'o376] = mk(8'o040, 5'd8, 1'b0, 1'b0);
      rom[8'o012] = mk(8'o200, 5'd5, 1'b1, 1'b1);
      test_reset();
      test_or_step();
      test_clk_ir();
      test_pause();
      test_force_trap();
      test_breakpoint();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
